// File: rtl/pt_pkg.sv
// pt_pkg: trit encodings, alpha waveforms, sync lengths and FSM states for the PT2262 encoder.
package pt_pkg;
  localparam logic [1:0] PT_ZERO = 2'b00;
  localparam logic [1:0] PT_ONE = 2'b01;
  localparam logic [1:0] PT_FLOAT = 2'b10;
  localparam logic [31:0] W_ZERO = 32'hF000_F000;
  localparam logic [31:0] W_ONE = 32'hFFF0_FFF0;
  localparam logic [31:0] W_FLOAT = 32'hF000_FFF0;
  localparam int SYNC_H = 4;
  localparam int SYNC_L = 124;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_SYNC} state_e;
endpackage

// File: rtl/pt_tick_gen.sv
// pt_tick_gen: CLK_DIV prescaler emitting a 1-cycle alpha tick, restartable at count 0.
module pt_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] cnt_q;
  assign tick = cnt_q == W'(CLK_DIV - 1);
  always_ff @(posedge clk)
    if (rst || restart || tick) cnt_q <= '0;
    else cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/pt2262_frame_tx.sv
// pt2262_frame_tx: PT2262 frame encoder (trits + sync, repeated); PT_CONT_EN adds a cont input.
module pt2262_frame_tx
  import pt_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int N_TRITS = 12,
  parameter int REPEATS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*N_TRITS-1:0] code_in,
  input  logic                 code_valid,
`ifdef PT_CONT_EN
  input  logic                 cont,
`endif
  output logic                 code_ready,
  output logic                 busy,
  output logic                 q,
  output logic                 frame_done
);
  localparam int REPS = REPEATS < 1 ? 1 : REPEATS;
  localparam int TW = N_TRITS > 1 ? $clog2(N_TRITS) : 1;
  localparam int RW = $clog2(REPS + 1);
  state_e state_q, state_d;
  logic [2*N_TRITS-1:0] word_q, word_d;
  logic [TW-1:0] trit_q, trit_d;
  logic [4:0] alpha_q, alpha_d;
  logic [6:0] sync_q, sync_d;
  logic [RW-1:0] rep_q, rep_d;
  logic q_q, q_d, busy_q, ready_q;
  logic tick, accept, last, go_on, sync_end, cont_w;
  logic [1:0] trit;
  logic [31:0] pat;
`ifdef PT_CONT_EN
  assign cont_w = cont;
`else
  assign cont_w = 1'b0;
`endif
  pt_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst(rst), .restart(accept), .tick(tick));
  assign code_ready = ready_q;
  assign busy = busy_q;
  assign q = q_q;
  assign accept = code_valid && ready_q;
  assign last = rep_q >= RW'(REPS - 1);
  assign go_on = cont_w || !last;
  assign sync_end = state_q == S_SYNC && tick && sync_q == 7'(SYNC_H + SYNC_L - 1);
  assign frame_done = sync_end && !go_on;
  // q is registered from the next-state view so the first alpha appears right after acceptance
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    trit_d = trit_q;
    alpha_d = alpha_q;
    sync_d = sync_q;
    rep_d = rep_q;
    if (state_q == S_IDLE && accept) begin
      state_d = S_DATA;
      word_d = code_in;
      trit_d = '0;
      alpha_d = '0;
      rep_d = '0;
    end else if (state_q == S_DATA && tick) begin
      alpha_d = alpha_q + 5'd1;
      if (alpha_q == 5'd31) begin
        if (trit_q == TW'(N_TRITS - 1)) begin
          state_d = S_SYNC;
          sync_d = '0;
        end else trit_d = trit_q + 1'b1;
      end
    end else if (state_q == S_SYNC && tick) begin
      sync_d = sync_q + 7'd1;
      if (sync_end) begin
        rep_d = last ? RW'(REPS) : rep_q + 1'b1;
        state_d = go_on ? S_DATA : S_IDLE;
        trit_d = '0;
        alpha_d = '0;
      end
    end
    trit = word_d[{trit_d, 1'b0} +: 2];
    pat = trit == PT_ZERO ? W_ZERO : trit == PT_ONE ? W_ONE : W_FLOAT;
    q_d = state_d == S_DATA ? pat[5'd31 - alpha_d] : state_d == S_SYNC && sync_d < 7'(SYNC_H);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IDLE;
      word_q <= '0;
      trit_q <= '0;
      alpha_q <= '0;
      sync_q <= '0;
      rep_q <= '0;
      q_q <= 1'b0;
      busy_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      trit_q <= trit_d;
      alpha_q <= alpha_d;
      sync_q <= sync_d;
      rep_q <= rep_d;
      q_q <= q_d;
      busy_q <= state_d != S_IDLE;
      ready_q <= state_d == S_IDLE;
    end
endmodule

// File: tb/tb_pt2262_frame_tx.sv
// tb_pt2262_frame_tx: directed frame checks on a CLK_DIV=1/REPEATS=1 and a CLK_DIV=3/REPEATS=2 encoder.
module tb_pt2262_frame_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:0] code_in = '0;
  logic valid = 1'b0;
  logic cont = 1'b0;
  int sel = 0;
  int vecs = 0;
  int errs = 0;
  logic ready_a, busy_a, q_a, fd_a, ready_b, busy_b, q_b, fd_b;
  logic ready_s, busy_s, q_s, fd_s;
  always #5 clk = ~clk;
  pt2262_frame_tx #(.CLK_DIV(1), .N_TRITS(12), .REPEATS(1)) u_a (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(valid && sel == 0),
`ifdef PT_CONT_EN
    .cont(cont),
`endif
    .code_ready(ready_a), .busy(busy_a), .q(q_a), .frame_done(fd_a));
  pt2262_frame_tx #(.CLK_DIV(3), .N_TRITS(12), .REPEATS(2)) u_b (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(valid && sel == 1),
`ifdef PT_CONT_EN
    .cont(1'b0),
`endif
    .code_ready(ready_b), .busy(busy_b), .q(q_b), .frame_done(fd_b));
  assign ready_s = sel == 1 ? ready_b : ready_a;
  assign busy_s = sel == 1 ? busy_b : busy_a;
  assign q_s = sel == 1 ? q_b : q_a;
  assign fd_s = sel == 1 ? fd_b : fd_a;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic expq(input logic [23:0] w, input int a);
    logic [1:0] t;
    logic [31:0] p;
    if (a >= 384) return (a - 384) < 4;
    t = w[2*(a/32) +: 2];
    p = t == 2'b00 ? 32'hF000_F000 : t == 2'b01 ? 32'hFFF0_FFF0 : 32'hF000_FFF0;
    return p[31 - (a % 32)];
  endfunction
  task automatic send(input logic [23:0] w);
    int n = 0;
    while (!ready_s && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(ready_s), 1);
    code_in = w;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask
  task automatic watch(input string tag, input logic [23:0] w, input int div, input int nfr, input int cont_drop);
    int bq = 0, bb = 0, bf = 0;
    int n = div * 512 * nfr;
    for (int k = 1; k <= n; k++) begin
      if (k == cont_drop) cont = 1'b0;
      if (q_s !== expq(w, ((k - 1) / div) % 512)) bq++;
      if (busy_s !== 1'b1 || ready_s !== 1'b0) bb++;
      if (fd_s !== (k == n)) bf++;
      @(negedge clk);
    end
    chk({tag, "_q"}, bq, 0);
    chk({tag, "_busy"}, bb, 0);
    chk({tag, "_done"}, bf, 0);
    chk({tag, "_end"}, {busy_s, ready_s, q_s, fd_s}, 4'b0100);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_q", q_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ready", ready_a, 0);
    chk("rst_done", fd_a, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready_a", ready_a, 1);
    chk("rel_ready_b", ready_b, 1);
    send(24'h000000);
    watch("zero", 24'h000000, 1, 1, 0);
    send(24'h00000D);
    chk("t2_first", q_a, 1);
    watch("onefloat", 24'h00000D, 1, 1, 0);
    send(24'hA5_96_3C);
    watch("mix", 24'hA5_96_3C, 1, 1, 0);
    sel = 1;
    send(24'h123456);
    watch("div3", 24'h123456, 3, 2, 0);
    sel = 0;
    send(24'h555555);
    code_in = 24'hAAAAAA;
    valid = 1'b1;
    watch("hold", 24'h555555, 1, 1, 0);
    @(negedge clk);
    valid = 1'b0;
    watch("after_hold", 24'hAAAAAA, 1, 1, 0);
    send(24'hFFF000);
    repeat (199) @(negedge clk);
    chk("pre_rst_busy", busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst", {busy_a, q_a, ready_a, fd_a}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", ready_a, 1);
    send(24'h0F0F0F);
    watch("post_rst", 24'h0F0F0F, 1, 1, 0);
`ifdef PT_CONT_EN
    cont = 1'b1;
    send(24'h3C3C3C);
    watch("cont", 24'h3C3C3C, 1, 4, 3 * 512 + 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
